pla_sweep_bist: RTL

- Exhaustive-sweep stimulus and response-compaction stage for the generated 10-input/6-output PLA blocks.
- Sits directly upstream of the PLA: drives every input code 0..2^N_IN-1 onto x_o. The PLA's x0 connects to x_o[0], x1 to x_o[1], and so on.
- Captures the PLA's z outputs on z_i. z0 connects to z_i[0], z1 to z_i[1], and so on.
- Folds every captured response into a MISR signature, which is compared against a software model for post-generation sign-off.

---
 rtl/pla_bist_pkg.sv | 31 +++
 rtl/pla_sweep_bist_if.sv | 25 ++
 rtl/pla_misr.sv | 41 ++++
 rtl/pla_sweep_bist.sv | 126 ++++++++++++
 4 files changed

// File: rtl/pla_bist_pkg.sv
// rtl/pla_bist_pkg.sv - shared state encoding, signature defaults and MISR step for the PLA sweep BIST
package pla_bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } bist_state_e;

  localparam int          MISR_W_DEF    = 16;
  localparam logic [15:0] MISR_POLY_DEF = 16'hD008;
  localparam logic [15:0] MISR_SEED_DEF = 16'hFFFF;

  // Galois MISR step on a signature of width w (1..32); bits above w are cleared.
  function automatic logic [31:0] misr_step(
    input logic [31:0] sig,
    input logic [31:0] resp,
    input logic [31:0] poly,
    input int unsigned w = MISR_W_DEF
  );
    logic [32:0] mask;
    logic [31:0] msb_word;
    logic [31:0] nxt;
    mask     = (33'd1 << w) - 33'd1;
    msb_word = sig >> (w - 1);
    nxt      = {sig[30:0], 1'b0} ^ (msb_word[0] ? poly : 32'd0) ^ resp;
    return nxt & mask[31:0];
  endfunction

endpackage

// File: rtl/pla_sweep_bist_if.sv
// rtl/pla_sweep_bist_if.sv - sweep control, PLA stimulus/response and signature bundle
interface pla_sweep_bist_if #(
  parameter int N_IN   = 10,
  parameter int N_OUT  = 6,
  parameter int MISR_W = 16
);
  logic              start;
  logic              abort;
  logic              hold;
  logic [N_IN-1:0]   x_o;
  logic [N_OUT-1:0]  z_i;
  logic              busy;
  logic              done;
  logic [MISR_W-1:0] sig_o;

  modport slave (
    input  start, abort, hold, z_i,
    output x_o, busy, done, sig_o
  );

  modport master (
    output start, abort, hold, z_i,
    input  x_o, busy, done, sig_o
  );
endinterface

// File: rtl/pla_misr.sv
// rtl/pla_misr.sv - parameterised Galois MISR with seed load and absorb enable
module pla_misr
  import pla_bist_pkg::*;
#(
  parameter int          W    = 16,
  parameter int          N    = 6,
  parameter logic [W-1:0] POLY = W'(MISR_POLY_DEF),
  parameter logic [W-1:0] SEED = W'(MISR_SEED_DEF)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic         en_i,
  input  logic [N-1:0] resp_i,
  output logic [W-1:0] sig_o
);

  logic [W-1:0] sig_q;
  logic [W-1:0] sig_d;

  // Seed load wins over absorb so a restart never folds a stale response.
  always_comb begin
    sig_d = sig_q;
    if (load_i) begin
      sig_d = SEED;
    end else if (en_i) begin
      sig_d = W'(misr_step(32'(sig_q), 32'(resp_i), 32'(POLY), W));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q <= SEED;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig_o = sig_q;

endmodule

// File: rtl/pla_sweep_bist.sv
// rtl/pla_sweep_bist.sv - exhaustive PLA input sweep with latency-aligned MISR response compaction
module pla_sweep_bist
  import pla_bist_pkg::*;
#(
  parameter int               N_IN      = 10,
  parameter int               N_OUT     = 6,
  parameter int               MISR_W    = 16,
  parameter logic [MISR_W-1:0] MISR_POLY = MISR_W'(MISR_POLY_DEF),
  parameter logic [MISR_W-1:0] MISR_SEED = MISR_W'(MISR_SEED_DEF),
  parameter int               RESP_LAT  = 1
) (
  input logic               clk,
  input logic               rst_n,
  pla_sweep_bist_if.slave   bus
);

  localparam logic [N_IN:0]     CNT_END   = {1'b1, {N_IN{1'b0}}};
  localparam logic [N_IN:0]     CNT_ONE   = {{N_IN{1'b0}}, 1'b1};
  localparam logic [RESP_LAT:0] VLD_FIRST = (RESP_LAT + 1)'(1);
  localparam logic [RESP_LAT:0] VLD_LAST  = VLD_FIRST << RESP_LAT;

  bist_state_e       state_q;
  logic [N_IN-1:0]   x_q;
  logic [N_IN:0]     cnt_q;
  logic [RESP_LAT:0] vld_q;
  logic              busy_q;
  logic              done_q;
  logic              misr_load;
  logic              misr_en;

  // vld_q[0] flags that x_o holds a freshly issued code; the top bit marks
  // the edge on which that code's response is valid on z_i.
  always_comb begin
    misr_load = 1'b0;
    misr_en   = 1'b0;
    if (bus.abort) begin
      misr_load = 1'b1;
    end else if ((state_q == ST_IDLE || state_q == ST_DONE) && bus.start) begin
      misr_load = 1'b1;
    end else if (state_q == ST_RUN || state_q == ST_DRAIN) begin
      misr_en = vld_q[RESP_LAT];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      cnt_q   <= '0;
      vld_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (bus.abort) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      cnt_q   <= '0;
      vld_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            state_q <= ST_RUN;
            x_q     <= '0;
            cnt_q   <= CNT_ONE;
            vld_q   <= VLD_FIRST;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        ST_RUN: begin
          if (cnt_q == CNT_END) begin
            // Last code is already on x_o; hold has nothing left to stall.
            vld_q <= vld_q << 1;
            if (RESP_LAT == 0) begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_DRAIN;
            end
          end else if (bus.hold) begin
            vld_q <= vld_q << 1;
          end else begin
            x_q   <= cnt_q[N_IN-1:0];
            cnt_q <= cnt_q + 1'b1;
            vld_q <= (vld_q << 1) | VLD_FIRST;
          end
        end
        ST_DRAIN: begin
          vld_q <= vld_q << 1;
          if (vld_q == VLD_LAST) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  pla_misr #(
    .W    (MISR_W),
    .N    (N_OUT),
    .POLY (MISR_POLY),
    .SEED (MISR_SEED)
  ) u_misr (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (misr_load),
    .en_i   (misr_en),
    .resp_i (bus.z_i),
    .sig_o  (bus.sig_o)
  );

  assign bus.x_o  = x_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule
